// File: rtl/rmw_input_shifter.sv
// Write-side field shifter for the configurable-aspect-ratio SRAM: places an LSB-aligned
// narrow write into its lane of a 32-bit macro row, using read-modify-write when W < 32.
module rmw_input_shifter #(
  parameter int DATA_W = 32,
  parameter int ROW_W  = 10,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        conf,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_din,
  output logic              done,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ROW_W-1:0]  mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_MERGE,
    S_WR,
    S_ERR
  } state_e;

  state_e state_q, state_d;

  logic [2:0]        conf_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] merged_q, merged_d;
  logic              done_q;

  logic              accept;
  logic [DATA_W-1:0] width_mask;
  logic [DATA_W-1:0] field_mask;
  logic [4:0]        shamt;
  logic [ROW_W-1:0]  row;

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid & req_ready;

  // Geometry is decoded from the captured request only, so the macro interface
  // never sees a combinational path from req_* inputs.
  // NOTE: every signal written in an always_comb gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    width_mask = 32'hFFFF_FFFF;
    shamt      = 5'd0;
    row        = addr_q[ROW_W-1:0];
    case (conf_q)
      3'd1: begin
        width_mask = 32'h0000_FFFF;
        shamt      = {addr_q[0], 4'b0000};
        row        = addr_q[1 +: ROW_W];
      end
      3'd2: begin
        width_mask = 32'h0000_00FF;
        shamt      = {addr_q[1:0], 3'b000};
        row        = addr_q[2 +: ROW_W];
      end
      3'd3: begin
        width_mask = 32'h0000_000F;
        shamt      = {addr_q[2:0], 2'b00};
        row        = addr_q[3 +: ROW_W];
      end
      3'd4: begin
        width_mask = 32'h0000_0003;
        shamt      = {addr_q[3:0], 1'b0};
        row        = addr_q[4 +: ROW_W];
      end
      3'd5: begin
        width_mask = 32'h0000_0001;
        shamt      = addr_q[4:0];
        row        = addr_q[5 +: ROW_W];
      end
      default: ;
    endcase
  end

  assign field_mask = width_mask << shamt;
  assign merged_d   = (mem_dout & ~field_mask) | ((din_q & width_mask) << shamt);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (conf == 3'd0)      state_d = S_WR;
          else if (conf <= 3'd5) state_d = S_RD;
          else                   state_d = S_ERR;
        end
      end
      S_RD:    state_d = S_MERGE;
      S_MERGE: state_d = S_WR;
      S_WR:    state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      conf_q   <= 3'd0;
      addr_q   <= '0;
      din_q    <= '0;
      merged_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_WR);
      if (accept) begin
        conf_q <= conf;
        addr_q <= req_addr;
        din_q  <= req_din;
      end
      if (state_q == S_MERGE) merged_q <= merged_d;
    end
  end

  // Full-width writes bypass the merge register and take the captured data as-is.
  always_comb begin
    mem_en   = (state_q == S_RD) || (state_q == S_WR);
    mem_we   = (state_q == S_WR);
    mem_addr = row;
    mem_din  = '0;
    if (state_q == S_WR) mem_din = (conf_q == 3'd0) ? din_q : merged_q;
  end

  assign done = done_q;
  assign err  = (state_q == S_ERR);

endmodule

// File: doc/rmw_input_shifter.md
Name: rmw_input_shifter

Overview:
- Write-side counterpart of the read-path output shifter for the configurable-aspect-ratio SRAM.
- Accepts an LSB-aligned narrow write (1 to 32 bits, selected by conf) at a logical address.
- Maps the address onto the 32-bit macro row and lane, and writes the field into place.
- The macro has no bit-mask input, so narrow writes are done as read-modify-write. Full-width writes go straight to the macro.

Parameters:
- DATA_W, 32, macro word width. Only 32 is supported; conf encoding depends on it.
- ROW_W, 10, macro row address width (1k rows).
- ADDR_W, 15, logical address width. Equals ROW_W+5, covering 32k x 1.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- conf  input  3  aspect ratio: 000 1kx32, 001 2kx16, 010 4kx8, 011 8kx4, 100 16kx2, 101 32kx1; 110/111 illegal
- req_valid  input  1  write request valid
- req_ready  output  1  block can accept a request
- req_addr  input  ADDR_W  logical address
- req_din  input  DATA_W  write data, LSB-aligned; bits at and above W are ignored
- done  output  1  one-cycle pulse: write committed
- err  output  1  one-cycle pulse: request dropped for illegal conf
- mem_en  output  1  macro enable
- mem_we  output  1  macro write enable, 1 = write
- mem_addr  output  ROW_W  macro row
- mem_din  output  DATA_W  macro write data
- mem_dout  input  DATA_W  macro read data, valid the cycle after a read cycle

Behaviour:
- Reset values: state=IDLE; req_ready=1; done=0; err=0; mem_en=0; mem_we=0; mem_addr=0; mem_din=0; all capture registers 0.
- Handshake:
  - Accept on a rising edge with req_valid & req_ready.
  - req_ready is 1 only in IDLE.
  - On accept, capture conf, req_addr and req_din; later input changes are ignored.
- Field geometry, with c = captured conf:
  - W = 32>>c
  - lane = addr[c-1:0] (0 when c=0)
  - row = addr[c+ROW_W-1:c]
  - mask = ((1<<W)-1) << (lane*W)
  - Address bits above c+ROW_W-1 are ignored.
- FSM:
  - IDLE: on accept, go to WR if c=000, RD if c in 001..101, ERR if c=110/111.
  - RD: mem_en=1, mem_we=0, mem_addr=row. Go to MERGE.
  - MERGE: mem_en=0. Register merged = (mem_dout & ~mask) | ((din[W-1:0] << lane*W) & mask). Go to WR.
  - WR: mem_en=1, mem_we=1, mem_addr=row. mem_din = din (c=000) or merged (otherwise). Go to IDLE, with done=1 in the next cycle.
  - ERR: no macro access. err=1 for this one cycle. Go to IDLE.
- mem_en, mem_we and mem_addr decode from registered state only; no combinational path from req_* to mem_*.
- Latency, accept edge to done high:
  - c=000: 2 cycles.
  - RMW: 4 cycles.
  - err is high 1 cycle after the accept edge.
- Back-to-back: the done cycle is an IDLE cycle with req_ready=1, so a new request can be accepted on that edge.
- Throughput: 1 write per 2 cycles (c=000) or per 4 cycles (RMW).
- conf changing while busy has no effect on the in-flight operation.
- Asynchronous reset in any state:
  - Immediately forces IDLE and drops mem_en, mem_we, done and err.
  - An interrupted RD or MERGE leaves the macro untouched.
  - WR interrupted before the clock edge does not commit.

Test Plan:
- Row 1 = 0xAABBCCDD; conf=010, addr=0x0006, din=0x123 -> RD row 1, WR row 1 with 0xAA23CCDD; done 4 cycles after accept.
- Row 0 = 0xFFFFFFFF; conf=101, addr=0x001F, din=0 -> WR 0x7FFFFFFF. Then conf=101, addr=0x0020, din=1 on row 1 = 0 -> WR 0x00000001.
- conf=000, addr=0x03FF, din=0xDEADBEEF -> no read cycle; mem_we=1, mem_addr=0x3FF, mem_din=0xDEADBEEF in the cycle after accept; done 2 cycles after accept.
- conf=110 with req_valid -> err pulse 1 cycle after accept; mem_en never high; req_ready back to 1 the next cycle.
- req_valid held high with two conf=001 requests (addr 0x0003 din 0xBEEF, then addr 0x0002 din 0x1234, row 1 = 0) -> second accepted on the done edge; final row 1 = 0xBEEF1234.
- rst_n low during MERGE -> mem_en=0 immediately, no WR issued, req_ready=1 after release, row contents unchanged.
